// File: rtl/ms_clk_pkg.sv
// rtl/ms_clk_pkg.sv - shared encodings for the MS clock-configuration sequencer
// Purpose: source encodings and sequencer state type used by ms_clk_ctrl.
package ms_clk_pkg;

  localparam logic [1:0] SRC_8M      = 2'd0;
  localparam logic [1:0] SRC_ROSC    = 2'd1;
  localparam logic [1:0] SRC_XCLK    = 2'd2;
  localparam logic [1:0] SRC_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PARK   = 3'd1,
    QUAL   = 3'd2,
    FAIL   = 3'd3,
    APPLY  = 3'd4,
    SETTLE = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/ms_clk_ctrl_sync.sv
// rtl/ms_clk_ctrl_sync.sv - xclk_tog synchroniser and edge detector
// Purpose: bring the XCLK/16 toggle into the clk domain and flag every transition.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   tog_i       toggle from the XCLK domain (asynchronous)
//   edge_o      one-cycle pulse per synchronised transition (either polarity)
module ms_clk_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_i,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tog_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Both rising and falling transitions count as a qualifying edge.
  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/ms_clk_ctrl.sv
// rtl/ms_clk_ctrl.sv - glitch-safe clock configuration sequencer
// Purpose: park the generator on 8 MHz, reprogram selects while parked,
//          qualify XCLK before use, then release the 8 MHz override.
// Ports:
//   clk, rst_n                     system clock, asynchronous active-low reset
//   cfg_req, cfg_src/rosc/div      configuration request, sampled in IDLE only
//   xclk_tog                       XCLK/16 toggle, asynchronous to clk
//   cfg_busy, cfg_ack, cfg_err     sequence status and completion pulse
//   sel_n_8mhz, sel_xclk           0 = force 8 MHz; 1 = XCLK / 0 = ROSC
//   sel_rosc, clk_div              ROSC trim and divider to the generator
module ms_clk_ctrl
  import ms_clk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int QUAL_EDGES    = 4,
  parameter int WD_LIMIT      = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [1:0] cfg_src,
  input  logic [1:0] cfg_rosc,
  input  logic [1:0] cfg_div,
  input  logic       xclk_tog,
  output logic       cfg_busy,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       sel_n_8mhz,
  output logic       sel_xclk,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int EW = $clog2(QUAL_EDGES) + 1;
  localparam int WW = $clog2(WD_LIMIT) + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST   = EW'(QUAL_EDGES - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(WD_LIMIT - 1);

  state_e state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;

  logic [1:0] req_src_q, req_src_d;
  logic [1:0] req_rosc_q, req_rosc_d;
  logic [1:0] req_div_q, req_div_d;

  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       n8_q, n8_d;
  logic       xclk_q, xclk_d;
  logic [1:0] rosc_q, rosc_d;
  logic [1:0] div_q, div_d;

  logic       tog_edge;
  logic [1:0] cur_src;
  logic       qual_ok;
  logic       qual_timeout;

  ms_clk_ctrl_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .tog_i  (xclk_tog),
    .edge_o (tog_edge)
  );

  // The running source is implied by the generator selects themselves, so a
  // failed qualification (which leaves 8 MHz forced) reads back as SRC_8M.
  assign cur_src = !n8_q ? SRC_8M : (xclk_q ? SRC_XCLK : SRC_ROSC);

  // The final edge wins over a simultaneous timeout.
  assign qual_ok      = tog_edge && (edge_cnt_q >= EDGE_LAST);
  assign qual_timeout = (wd_cnt_q >= WD_LAST);

  always_comb begin
    state_d    = state_q;
    req_src_d  = req_src_q;
    req_rosc_d = req_rosc_q;
    req_div_d  = req_div_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    n8_d       = n8_q;
    xclk_d     = xclk_q;
    rosc_d     = rosc_q;
    div_d      = div_q;

    case (state_q)
      IDLE: begin
        // Blocking accept during the ack cycle keeps one ack per request.
        if (cfg_req && !ack_q) begin
          if (cfg_src == SRC_ILLEGAL) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (cfg_src == cur_src && cfg_rosc == rosc_q && cfg_div == div_q) begin
            ack_d = 1'b1;
          end else begin
            req_src_d  = cfg_src;
            req_rosc_d = cfg_rosc;
            req_div_d  = cfg_div;
            n8_d       = 1'b0;
            busy_d     = 1'b1;
            state_d    = PARK;
          end
        end
      end
      PARK: begin
        if (settle_cnt_q >= SETTLE_LAST)
          state_d = (req_src_q == SRC_XCLK) ? QUAL : APPLY;
      end
      QUAL: begin
        if (qual_ok)           state_d = APPLY;
        else if (qual_timeout) state_d = FAIL;
      end
      FAIL: begin
        xclk_d  = 1'b0;
        ack_d   = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      APPLY: begin
        xclk_d  = (req_src_q == SRC_XCLK);
        rosc_d  = req_rosc_q;
        div_d   = req_div_q;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Completion outputs are registered on entry to DONE.
        if (settle_cnt_q >= SETTLE_LAST) begin
          n8_d    = (req_src_q != SRC_8M);
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters restart on every state change and saturate rather than wrap.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    if (state_d != state_q) begin
      settle_cnt_d = '0;
      edge_cnt_d   = '0;
      wd_cnt_d     = '0;
    end else begin
      if ((state_q == PARK || state_q == SETTLE) && settle_cnt_q != '1)
        settle_cnt_d = settle_cnt_q + SW'(1);
      if (state_q == QUAL) begin
        if (wd_cnt_q != '1)
          wd_cnt_d = wd_cnt_q + WW'(1);
        if (tog_edge && edge_cnt_q != '1)
          edge_cnt_d = edge_cnt_q + EW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      edge_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      req_src_q    <= '0;
      req_rosc_q   <= '0;
      req_div_q    <= '0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      n8_q         <= 1'b0;
      xclk_q       <= 1'b0;
      rosc_q       <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      req_src_q    <= req_src_d;
      req_rosc_q   <= req_rosc_d;
      req_div_q    <= req_div_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      n8_q         <= n8_d;
      xclk_q       <= xclk_d;
      rosc_q       <= rosc_d;
      div_q        <= div_d;
    end
  end

  assign cfg_busy   = busy_q;
  assign cfg_ack    = ack_q;
  assign cfg_err    = err_q;
  assign sel_n_8mhz = n8_q;
  assign sel_xclk   = xclk_q;
  assign sel_rosc   = rosc_q;
  assign clk_div    = div_q;

endmodule

// File: tb/tb_ms_clk_ctrl.sv
// tb/tb_ms_clk_ctrl.sv - scoreboard bench for ms_clk_ctrl
module tb_ms_clk_ctrl;

  localparam int SETTLE_CYCLES = 16;
  localparam int QUAL_EDGES    = 4;
  localparam int WD_LIMIT      = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_src = 2'd0;
  logic [1:0] cfg_rosc = 2'd0;
  logic [1:0] cfg_div = 2'd0;
  logic       xclk_tog = 1'b0;
  logic       cfg_busy, cfg_ack, cfg_err, sel_n_8mhz, sel_xclk;
  logic [1:0] sel_rosc, clk_div;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acks = 0;
  int pushed = 0;
  int n8_low_run = 0;
  bit xclk_run = 1'b0;
  logic [4:0] prev_sel = 5'd0;

  typedef struct {
    int         cmin;
    int         cmax;
    logic       err;
    logic       n8;
    logic       xc;
    logic [1:0] rosc;
    logic [1:0] div;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ms_clk_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .QUAL_EDGES    (QUAL_EDGES),
    .WD_LIMIT      (WD_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_src    (cfg_src),
    .cfg_rosc   (cfg_rosc),
    .cfg_div    (cfg_div),
    .xclk_tog   (xclk_tog),
    .cfg_busy   (cfg_busy),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .sel_n_8mhz (sel_n_8mhz),
    .sel_xclk   (sel_xclk),
    .sel_rosc   (sel_rosc),
    .clk_div    (clk_div)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // XCLK/16 at 25 MHz: a transition every 320 ns, offset from clk edges.
  initial begin
    #3;
    forever begin
      #320;
      if (xclk_run) xclk_tog = ~xclk_tog;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per ack, and checks that selects only move
  // after sel_n_8mhz has been low for at least SETTLE_CYCLES samples.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cfg_ack) begin
          acks++;
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ack_cycle_in_window", int'(cyc >= mon_e.cmin && cyc <= mon_e.cmax), 1);
            chk("ack_err", cfg_err, mon_e.err);
            chk("ack_sel_n_8mhz", sel_n_8mhz, mon_e.n8);
            chk("ack_sel_xclk", sel_xclk, mon_e.xc);
            chk("ack_sel_rosc", sel_rosc, mon_e.rosc);
            chk("ack_clk_div", clk_div, mon_e.div);
            chk("ack_busy_low", cfg_busy, 0);
          end
        end
        if ({sel_xclk, sel_rosc, clk_div} != prev_sel)
          chk("sel_change_while_parked", int'(n8_low_run >= SETTLE_CYCLES), 1);
        prev_sel = {sel_xclk, sel_rosc, clk_div};
        if (!sel_n_8mhz) n8_low_run++;
        else n8_low_run = 0;
      end else begin
        prev_sel = 5'd0;
        n8_low_run = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] src, input logic [1:0] rosc, input logic [1:0] div,
                       input int lmin, input int lmax, input logic eerr, input logic en8,
                       input logic exc, input logic [1:0] erosc, input logic [1:0] ediv,
                       output int c0);
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    cfg_src  = src;
    cfg_rosc = rosc;
    cfg_div  = div;
    cfg_req  = 1'b1;
    e.cmin = c0 + lmin;
    e.cmax = c0 + lmax;
    e.err  = eerr;
    e.n8   = en8;
    e.xc   = exc;
    e.rosc = erosc;
    e.div  = ediv;
    exp_q.push_back(e);
    pushed++;
    @(negedge clk);
    cfg_req = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (acks < pushed && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ack_arrived", int'(acks >= pushed), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, cfg_busy, 0);
    chk({tag, "_ack"}, cfg_ack, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_n8"}, sel_n_8mhz, 0);
    chk({tag, "_xclk"}, sel_xclk, 0);
    chk({tag, "_rosc"}, sel_rosc, 0);
    chk({tag, "_div"}, clk_div, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0 (cycle %0d)", 1, cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    int a0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ROSC request: park, apply in cycle 18, release with ack in cycle 34.
    issue(2'd1, 2'd3, 2'd0, 34, 34, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, c0);
    wait_to(c0 + 1);
    chk("rosc_n8_c1", sel_n_8mhz, 0);
    chk("rosc_busy_c1", cfg_busy, 1);
    wait_to(c0 + 17);
    chk("rosc_sel_rosc_c17", sel_rosc, 0);
    wait_to(c0 + 18);
    chk("rosc_sel_rosc_c18", sel_rosc, 3);
    wait_to(c0 + 33);
    chk("rosc_n8_c33", sel_n_8mhz, 0);
    wait_ack(100);

    // Repeat of the current configuration: ack next edge, 8 MHz never forced.
    issue(2'd1, 2'd3, 2'd0, 1, 1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, c0);
    wait_to(c0 + 1);
    chk("noop_n8_c1", sel_n_8mhz, 1);
    chk("noop_busy_c1", cfg_busy, 0);
    wait_ack(10);
    wait_to(c0 + 2);
    chk("noop_n8_c2", sel_n_8mhz, 1);

    // Illegal source: ack with err, no output change.
    issue(2'd3, 2'd0, 2'd1, 1, 1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0, c0);
    wait_ack(10);

    // Divider sweep with an illegal request injected while busy.
    for (int d = 1; d <= 3; d++) begin
      issue(2'd1, 2'd3, 2'(d), 34, 34, 1'b0, 1'b1, 1'b0, 2'd3, 2'(d), c0);
      wait_to(c0 + 1);
      chk("sweep_n8_c1", sel_n_8mhz, 0);
      wait_to(c0 + 10);
      cfg_src = 2'd3;
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("sweep_busy_c11", cfg_busy, 1);
      wait_to(c0 + 17);
      chk("sweep_div_c17", clk_div, d - 1);
      wait_to(c0 + 18);
      chk("sweep_div_c18", clk_div, d);
      wait_ack(100);
    end

    // XCLK with the toggle running: qualifies within the watchdog window.
    xclk_run = 1'b1;
    issue(2'd2, 2'd3, 2'd3, 35, 34 + WD_LIMIT, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3, c0);
    wait_ack(400);
    xclk_run = 1'b0;
    repeat (8) @(negedge clk);

    // XCLK with the toggle stopped: timeout ack in cycle 274, XCLK deselected.
    issue(2'd2, 2'd1, 2'd3, SETTLE_CYCLES + WD_LIMIT + 2, SETTLE_CYCLES + WD_LIMIT + 2,
          1'b1, 1'b0, 1'b0, 2'd3, 2'd3, c0);
    wait_to(c0 + 273);
    chk("fail_busy_c273", cfg_busy, 1);
    chk("fail_ack_c273", cfg_ack, 0);
    wait_ack(400);

    // Back to plain 8 MHz with new trim and divider.
    issue(2'd0, 2'd0, 2'd0, 34, 34, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, c0);
    wait_ack(100);

    // Reset mid-sequence after the selects were applied.
    issue(2'd1, 2'd2, 2'd2, 34, 34, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, c0);
    wait_to(c0 + 20);
    chk("pre_reset_rosc", sel_rosc, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    pushed = acks;
    a0 = acks;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_ack_after_reset", acks - a0, 0);
    chk_all_zero("post_reset");

    chk("expect_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
